fix_trailer_gen: RTL and testbench
==================================

FIX_TRAILER_GEN -- requirements
Module: fix_trailer_gen

Interface
REQ-001 SHALL have parameter NUM_HOST, default 2, number of independent upstream message sources (1..8).
REQ-002 SHALL have parameter CHKSUM_EN, default 1; 1 = append FIX CheckSum trailer, 0 = pass-through only.
REQ-003 SHALL have port clk  input  1  single clock for all logic, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port msg_valid_i  input  NUM_HOST  per-host byte valid.
REQ-006 SHALL have port msg_data_i  input  8*NUM_HOST  per-host body byte; host h occupies bits [8h+7:8h].
REQ-007 SHALL have port msg_last_i  input  NUM_HOST  per-host last-body-byte flag, qualified by msg_valid_i.
REQ-008 SHALL have port msg_ready_o  output  NUM_HOST  per-host accept; a byte transfers when valid and ready are both high.
REQ-009 SHALL have port fifo_full_i  input  1  downstream FIFO full.
REQ-010 SHALL have port fifo_write_o  output  1  downstream FIFO write strobe.
REQ-011 SHALL have port message_o  output  8  byte written to the FIFO.
REQ-012 SHALL have port end_o  output  1  marks the final byte of a message, high only together with fifo_write_o.
REQ-013 SHALL have port host_o  output  max(1,$clog2(NUM_HOST))  index of the host owning the current message_o byte.
REQ-014 SHALL have port busy_o  output  1  high from grant until the final byte is written.

Function
REQ-015 SHALL contain a one-entry output register (out_valid, byte, end, host); fifo_write_o = out_valid AND NOT fifo_full_i, combinationally.
REQ-016 SHALL hold the output register unchanged while out_valid and fifo_full_i are both high; no byte is dropped or duplicated.
REQ-017 SHALL use states IDLE, PASS, T1, T0, EQ, D2, D1, D0, SOH.
REQ-018 In IDLE, SHALL grant round-robin among hosts with msg_valid_i high, searching from (last granted + 1) mod NUM_HOST, then enter PASS; after reset the search starts at host 0.
REQ-019 SHALL lock the grant for a whole message; other hosts see msg_ready_o low until the granted message's trailer has been loaded.
REQ-020 In PASS, msg_ready_o[grant] SHALL equal NOT out_valid OR NOT fifo_full_i; all other ready bits are 0.
REQ-021 Each accepted byte SHALL be loaded into the output register on the same edge: one-cycle latency to message_o.
REQ-022 SHALL accumulate an 8-bit checksum, sum mod 256 of every accepted body byte; it clears at grant.
REQ-023 On acceptance of a last byte with CHKSUM_EN=1, SHALL go to T1.
REQ-024 States T1, T0, EQ, D2, D1, D0, SOH SHALL each load one byte, in that order: 0x31, 0x30, 0x3D, hundreds, tens and units digits of the checksum as ASCII (0x30+d, zero-padded), then 0x01.
REQ-025 Each trailer state SHALL advance only when the output register is free or being written that cycle.
REQ-026 end_o SHALL accompany the 0x01 byte loaded in SOH; the FSM then returns to IDLE.
REQ-027 With CHKSUM_EN=0, end_o SHALL accompany the last body byte; the FSM returns to IDLE with no trailer.
REQ-028 Digit conversion SHALL be exact for 0..255; it may be computed at entry to T1 and held.
REQ-029 A gap in msg_valid_i mid-message SHALL stall without output; the grant and checksum are held.
REQ-030 A single-byte message (valid and last on the first transfer) SHALL be legal and produce a full trailer.
REQ-031 A new grant MAY occur in the cycle after SOH loads; the back-to-back message throughput shall not lose bytes.

Reset
REQ-032 While rst is low: fifo_write_o=0, message_o=0x00, end_o=0, host_o=0, busy_o=0, msg_ready_o=0, state=IDLE, checksum=0, round-robin pointer=0.
REQ-033 A reset mid-message or mid-trailer SHALL abandon the message; no partial trailer is emitted after release.

Verification
REQ-034 Host 0 sends 33 35 3D 30 01 (last on 01), fifo_full_i=0 -> message_o = 33 35 3D 30 01 31 30 3D 32 31 34 01 on 12 consecutive writes, end_o only on the final 01, host_o=0.
REQ-035 Body 80 80 -> trailer digits 30 30 30 (checksum 0); body FF -> digits 32 35 35.
REQ-036 Both hosts have valid asserted continuously -> messages alternate 0,1,0,1, and each message's bytes are contiguous with no interleaving.
REQ-037 fifo_full_i is held high for 5 cycles during EQ -> fifo_write_o=0 and message_o is stable at 3D throughout; the trailer then resumes with no loss.
REQ-038 rst is pulsed low during D1 -> all outputs are 0 immediately; the next message starts cleanly with its checksum cleared.
REQ-039 CHKSUM_EN=0, body 41 01 -> output is 41 01 with end_o on 01, and no trailer.

Source files
------------

// File: rtl/fix_trailer_gen.sv
// Streams FIX message bodies from several hosts into one FIFO, round-robin per message,
// and appends the "10=nnn<SOH>" CheckSum trailer after each body when CHKSUM_EN is set.
module fix_trailer_gen #(
  parameter int NUM_HOST  = 2,
  parameter int CHKSUM_EN = 1,
  localparam int HW = (NUM_HOST > 1) ? $clog2(NUM_HOST) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HOST-1:0]   msg_valid_i,
  input  logic [8*NUM_HOST-1:0] msg_data_i,
  input  logic [NUM_HOST-1:0]   msg_last_i,
  output logic [NUM_HOST-1:0]   msg_ready_o,
  input  logic                  fifo_full_i,
  output logic                  fifo_write_o,
  output logic [7:0]            message_o,
  output logic                  end_o,
  output logic [HW-1:0]         host_o,
  output logic                  busy_o
);

  typedef enum logic [3:0] {IDLE, PASS, T1, T0, EQ, D2, D1, D0, SOH} state_t;

  state_t        state_q, state_d, tr_next;
  logic [HW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, cand;
  logic [7:0]    sum_q, sum_d, in_byte, tr_byte;
  logic [9:0]    bcd_q, bcd_d;
  logic          out_vld_q, out_vld_d, out_end_q, out_end_d;
  logic [7:0]    out_byte_q, out_byte_d;
  logic [HW-1:0] out_host_q, out_host_d;
  logic          out_free, found, is_tr;

  // Packs hundreds[9:8], tens[7:4], units[3:0] of an 8-bit value.
  function automatic logic [9:0] to_bcd(input logic [7:0] s);
    logic [1:0] h;
    logic [7:0] r;
    h = (s >= 8'd200) ? 2'd2 : ((s >= 8'd100) ? 2'd1 : 2'd0);
    r = s - 8'(h) * 8'd100;
    return {h, 4'(r / 8'd10), 4'(r % 8'd10)};
  endfunction

  assign out_free     = ~out_vld_q | ~fifo_full_i;
  assign fifo_write_o = out_vld_q & ~fifo_full_i;
  assign end_o        = out_end_q & fifo_write_o;
  assign message_o    = out_byte_q;
  assign host_o       = out_host_q;
  assign busy_o       = (state_q != IDLE) | (out_vld_q & out_end_q);
  assign in_byte      = msg_data_i[8*int'(gnt_q) +: 8];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    bcd_d       = bcd_q;
    out_vld_d   = out_vld_q & ~out_free;
    out_byte_d  = out_byte_q;
    out_end_d   = out_end_q;
    out_host_d  = out_host_q;
    msg_ready_o = '0;
    found       = 1'b0;
    cand        = '0;
    is_tr       = 1'b1;
    tr_byte     = 8'h00;
    tr_next     = IDLE;
    case (state_q)
      IDLE: begin
        is_tr = 1'b0;
        for (int i = 0; i < NUM_HOST; i++) begin
          cand = HW'((int'(ptr_q) + i) % NUM_HOST);
          if (!found && msg_valid_i[cand]) begin
            found   = 1'b1;
            gnt_d   = cand;
            ptr_d   = HW'((int'(cand) + 1) % NUM_HOST);
            sum_d   = 8'h00;
            state_d = PASS;
          end
        end
      end
      PASS: begin
        is_tr = 1'b0;
        msg_ready_o[gnt_q] = out_free;
        if (msg_valid_i[gnt_q] && out_free) begin
          out_vld_d  = 1'b1;
          out_byte_d = in_byte;
          out_end_d  = msg_last_i[gnt_q] && (CHKSUM_EN == 0);
          out_host_d = gnt_q;
          sum_d      = sum_q + in_byte;
          if (msg_last_i[gnt_q]) begin
            if (CHKSUM_EN != 0) begin
              state_d = T1;
              bcd_d   = to_bcd(sum_d);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      T1:  begin tr_byte = 8'h31;                  tr_next = T0;  end
      T0:  begin tr_byte = 8'h30;                  tr_next = EQ;  end
      EQ:  begin tr_byte = 8'h3D;                  tr_next = D2;  end
      D2:  begin tr_byte = {6'b001100, bcd_q[9:8]}; tr_next = D1;  end
      D1:  begin tr_byte = {4'h3, bcd_q[7:4]};      tr_next = D0;  end
      D0:  begin tr_byte = {4'h3, bcd_q[3:0]};      tr_next = SOH; end
      SOH: begin tr_byte = 8'h01;                  tr_next = IDLE; end
      default: begin
        is_tr   = 1'b0;
        state_d = IDLE;
      end
    endcase
    // Trailer bytes advance only into a free (or draining) output register.
    if (is_tr && out_free) begin
      out_vld_d  = 1'b1;
      out_byte_d = tr_byte;
      out_end_d  = (state_q == SOH);
      out_host_d = gnt_q;
      state_d    = tr_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      sum_q      <= 8'h00;
      bcd_q      <= '0;
      out_vld_q  <= 1'b0;
      out_byte_q <= 8'h00;
      out_end_q  <= 1'b0;
      out_host_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      sum_q      <= sum_d;
      bcd_q      <= bcd_d;
      out_vld_q  <= out_vld_d;
      out_byte_q <= out_byte_d;
      out_end_q  <= out_end_d;
      out_host_q <= out_host_d;
    end
  end

endmodule

// File: tb/tb_fix_trailer_gen.sv
// Randomized bench for fix_trailer_gen: per-host message queues feed the DUT and a
// scoreboard built from the FIX checksum rules predicts every byte written.
module tb_fix_trailer_gen;
  localparam int NH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NH-1:0] msg_valid_i, msg_last_i, msg_ready_o;
  logic [8*NH-1:0] msg_data_i;
  logic          fifo_full_i, fifo_write_o, end_o, busy_o, host_o;
  logic [7:0]    message_o;

  logic [NH-1:0] v_n, l_n, r_n;
  logic [8*NH-1:0] d_n;
  logic          full_n, wr_n, end_n, busy_n, host_n;
  logic [7:0]    msg_n;

  fix_trailer_gen #(.NUM_HOST(NH), .CHKSUM_EN(1)) dut (
    .clk(clk), .rst(rst), .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i),
    .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o), .fifo_full_i(fifo_full_i),
    .fifo_write_o(fifo_write_o), .message_o(message_o), .end_o(end_o),
    .host_o(host_o), .busy_o(busy_o));

  fix_trailer_gen #(.NUM_HOST(NH), .CHKSUM_EN(0)) dut_nochk (
    .clk(clk), .rst(rst), .msg_valid_i(v_n), .msg_data_i(d_n),
    .msg_last_i(l_n), .msg_ready_o(r_n), .fifo_full_i(full_n),
    .fifo_write_o(wr_n), .message_o(msg_n), .end_o(end_n),
    .host_o(host_n), .busy_o(busy_n));

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] d; logic l;} beat_t;
  beat_t       src_q[NH][$];
  beat_t       exp_q[NH][$];
  logic [7:0]  body_q[$];

  int   n_chk = 0, n_fail = 0, cyc = 0, wr_cnt = 0;
  int   gap_pct = 0, full_pct = 0;
  logic force_full = 1'b0;
  logic [NH-1:0] acc = '0;
  bit   in_msg = 0, have_prev = 0, chk_alt = 0, strict = 0, wr_flag = 0;
  int   cur_host = 0, prev_host = 0, last_wr = 0;
  logic [7:0] wr_byte = 8'h00, prev_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue one message from body_q: body bytes, then "10=" + 3 ASCII digits + SOH.
  task automatic add_msg(input int h);
    int sum;
    logic [7:0] tr[7];
    sum = 0;
    for (int i = 0; i < body_q.size(); i++) begin
      src_q[h].push_back('{d: body_q[i], l: (i == body_q.size() - 1)});
      exp_q[h].push_back('{d: body_q[i], l: 1'b0});
      sum = (sum + int'(body_q[i])) % 256;
    end
    tr = '{8'h31, 8'h30, 8'h3D, 8'(48 + sum / 100), 8'(48 + (sum / 10) % 10),
           8'(48 + sum % 10), 8'h01};
    for (int i = 0; i < 7; i++) exp_q[h].push_back('{d: tr[i], l: (i == 6)});
  endtask

  task automatic rand_body();
    int len;
    body_q.delete();
    len = int'($urandom_range(6, 1));
    for (int i = 0; i < len; i++) body_q.push_back(8'($urandom));
  endtask

  function automatic bit pending();
    int n;
    n = 0;
    for (int h = 0; h < NH; h++) n += src_q[h].size() + exp_q[h].size();
    return n != 0;
  endfunction

  task automatic step();
    int h;
    beat_t e;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NH; k++)
      if (acc[k] && src_q[k].size() > 0) src_q[k].delete(0);
    for (int k = 0; k < NH; k++) begin
      if (src_q[k].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        msg_valid_i[k]        = 1'b1;
        msg_data_i[8*k +: 8]  = src_q[k][0].d;
        msg_last_i[k]         = src_q[k][0].l;
      end else begin
        msg_valid_i[k]        = 1'b0;
        msg_data_i[8*k +: 8]  = 8'($urandom);
        msg_last_i[k]         = 1'($urandom);
      end
    end
    fifo_full_i = force_full | (int'($urandom_range(99)) < full_pct);
    #1;
    acc = msg_valid_i & msg_ready_o;
    check("ready_onehot", 32'($countones(msg_ready_o) <= 1), 32'd1);
    wr_flag = fifo_write_o;
    if (fifo_write_o) begin
      wr_cnt++;
      h = int'(host_o);
      check("has_expect", 32'(exp_q[h].size() > 0), 32'd1);
      check("busy_on_write", 32'(busy_o), 32'd1);
      if (exp_q[h].size() > 0) begin
        e = exp_q[h][0];
        exp_q[h].delete(0);
        check("byte", 32'(message_o), 32'(e.d));
        check("end", 32'(end_o), 32'(e.l));
      end
      if (in_msg) begin
        check("host_contig", 32'(h), 32'(cur_host));
        if (strict) check("consecutive", 32'(cyc), 32'(last_wr + 1));
      end else begin
        in_msg   = 1;
        cur_host = h;
        if (chk_alt && have_prev) check("alternate", 32'(h), 32'(prev_host ^ 1));
      end
      last_wr   = cyc;
      prev_byte = wr_byte;
      wr_byte   = message_o;
      if (end_o) begin
        in_msg    = 0;
        prev_host = cur_host;
        have_prev = 1;
      end
    end else begin
      check("end_without_write", 32'(end_o), 32'd0);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending() || busy_o) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_write", 32'(fifo_write_o), 32'd0);
    check("rst_msg", 32'(message_o), 32'd0);
    check("rst_end", 32'(end_o), 32'd0);
    check("rst_host", 32'(host_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(msg_ready_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int w0, idx, nw;
    bit a0;
    logic [7:0] b0[2];

    rst = 1'b0;
    msg_valid_i = '1; msg_data_i = '0; msg_last_i = '0; fifo_full_i = 1'b0;
    v_n = '1; d_n = '0; l_n = '0; full_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    check("rst_nochk_write", 32'(wr_n), 32'd0);
    check("rst_nochk_ready", 32'(r_n), 32'd0);
    @(negedge clk);
    msg_valid_i = '0; v_n = '0;
    rst = 1'b1;

    // Reference message, strictly back-to-back output
    strict = 1;
    w0 = wr_cnt;
    body_q = '{8'h33, 8'h35, 8'h3D, 8'h30, 8'h01};
    add_msg(0);
    drain(100);
    check("ref_write_count", 32'(wr_cnt - w0), 32'd12);
    strict = 0;

    // Checksum wrap to 000 and maximum single byte 255
    body_q = '{8'h80, 8'h80}; add_msg(0);
    body_q = '{8'hFF};        add_msg(0);
    drain(100);

    // Back-pressure while the '=' byte sits in the output register
    body_q = '{8'h41, 8'h42}; add_msg(1);
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      if (wr_flag && wr_byte == 8'h30 && prev_byte == 8'h31) found = 1;
    end
    check("reach_t0", 32'(found), 32'd1);
    force_full = 1'b1;
    repeat (5) begin
      step();
      check("full_no_write", 32'(fifo_write_o), 32'd0);
      check("full_hold_byte", 32'(message_o), 32'h3D);
    end
    force_full = 1'b0;
    drain(100);

    // Reset while the tens digit is being produced
    body_q = '{8'h41, 8'h42}; add_msg(0);
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      if (wr_flag && wr_byte == 8'h3D) found = 1;
    end
    check("reach_eq_write", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    for (int h = 0; h < NH; h++) begin src_q[h].delete(); exp_q[h].delete(); end
    acc = '0; in_msg = 0; have_prev = 0; msg_valid_i = '0;
    @(negedge clk);
    rst = 1'b1;
    body_q = '{8'h41}; add_msg(0);
    drain(100);

    // Both hosts continuously valid: whole messages alternate
    chk_alt = 1; have_prev = 0; full_pct = 20;
    for (int m = 0; m < 3; m++)
      for (int h = 0; h < NH; h++) begin rand_body(); add_msg(h); end
    drain(600);
    chk_alt = 0;

    // Random traffic with gaps and back-pressure
    gap_pct = 30; full_pct = 30;
    for (int m = 0; m < 16; m++) begin rand_body(); add_msg(int'($urandom_range(NH - 1))); end
    drain(3000);
    gap_pct = 0; full_pct = 0;

    // Pass-through instance: body only, end on last body byte
    b0 = '{8'h41, 8'h01};
    idx = 0; nw = 0; a0 = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a0) idx++;
      v_n[0] = (idx < 2);
      d_n[7:0] = (idx < 2) ? b0[idx] : 8'h00;
      l_n[0] = (idx == 1);
      #1;
      a0 = v_n[0] & r_n[0];
      if (wr_n) begin
        if (nw < 2) begin
          check("nochk_byte", 32'(msg_n), 32'(b0[nw]));
          check("nochk_end", 32'(end_n), 32'(nw == 1));
          check("nochk_host", 32'(host_n), 32'd0);
        end else begin
          check("nochk_extra_write", 32'(nw), 32'd1);
        end
        nw++;
      end
    end
    check("nochk_count", 32'(nw), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
